// File: rtl/mem_responder_if.sv
// Handshake bundle between the datapath's MAR/MDR memory port (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_busy;
  logic              mem_ready;
  logic              req_err;

  modport master (
    output Read, Write, addr, wdata,
    input  Mdatain, mem_busy, mem_ready, req_err
  );

  modport slave (
    input  Read, Write, addr, wdata,
    output Mdatain, mem_busy, mem_ready, req_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: latches a Read/Write request, inserts WAIT_CYCLES wait states, then
// reads/writes the array and pulses mem_ready. Define MEM_PROTECT_EN to write-protect [0, PROTECT_TOP).
module mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned PROTECT_TOP = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_accept;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;

  logic [DATA_W-1:0] r_mdatain;
  logic              r_ready;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic              w_protected;
  logic              w_both;
  logic              w_err;
  logic              w_do_read;
  logic              w_do_write;

  // Next-state and wait counter; the counter is only meaningful while in ST_WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Read || bus.Write) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ACCESS: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Request classification from the latched copy only, so input wiggles mid-flight are harmless.
  always_comb begin
    w_in_range  = (32'(r_addr) < DEPTH);
    w_both      = r_rd && r_wr;
    w_protected = PROT_EN && r_wr && !r_rd && (32'(r_addr) < PROTECT_TOP);
    w_err       = w_both || !w_in_range || w_protected;
    w_do_read   = (r_state == ST_ACCESS) && r_rd && !r_wr;
    w_do_write  = (r_state == ST_ACCESS) && r_wr && !r_rd && w_in_range && !w_protected;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_mdatain <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_rd    <= bus.Read;
        r_wr    <= bus.Write;
      end
      r_ready <= (r_state == ST_ACCESS);
      r_err   <= (r_state == ST_ACCESS) && w_err;
      if (w_do_read) begin
        r_mdatain <= w_in_range ? r_mem[r_addr[IDX_W-1:0]] : '0;
      end
    end
  end

  // Array has no reset; the rst gate keeps an aborted request from committing.
  always_ff @(posedge clk) begin
    if (w_do_write && !rst) begin
      r_mem[r_addr[IDX_W-1:0]] <= r_wdata;
    end
  end

  assign bus.Mdatain   = r_mdatain;
  assign bus.mem_busy  = (r_state == ST_WAIT) || (r_state == ST_ACCESS);
  assign bus.mem_ready = r_ready;
  assign bus.req_err   = r_err;

endmodule
